// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-chained
// chunks, one chunk per pipeline stage, with valid/ready on both sides.
// Optional flags (signed overflow, zero) are built only when the FLAGS_EN
// macro is defined; otherwise overflow and zero are tied to 0.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_0,
  input  logic [WIDTH-1:0] input_1,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int          CHUNK = WIDTH / STAGES;
  // Inter-stage register count; kept at least 1 so STAGES=1 still elaborates.
  localparam int          PIPE  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned LAST  = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // Registers between stage k and stage k+1 (the last stage feeds the
  // output registers directly). Operands travel whole; each stage only
  // consumes its own chunk, so upper chunks arrive skewed into their stage
  // and finished lower sum chunks are carried along to align at the output.
  logic [WIDTH-1:0] a_q [PIPE];
  logic [WIDTH-1:0] b_q [PIPE];
  logic [WIDTH-1:0] s_q [PIPE];
  logic             c_q [PIPE];
  logic             v_q [PIPE];

  // Per-stage inputs and combinational results.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_nx [STAGES];
  logic [CHUNK:0]   part;

  // All stages move together; the pipe only stalls when a result is waiting.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~input_1 : input_1;

  // Chunk adders: stage k adds chunk k of A and B' plus the carry from k-1.
  always_comb begin
    part    = '0;
    a_in[0] = input_0;
    b_in[0] = b_eff;
    s_in[0] = '0;
    c_in[0] = carry_in;
    v_in[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      part    = {1'b0, CHUNK'(a_in[k] >> (k * CHUNK))}
              + {1'b0, CHUNK'(b_in[k] >> (k * CHUNK))}
              + {{CHUNK{1'b0}}, c_in[k]};
      s_nx[k] = s_in[k] | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));
      c_nx[k] = part[CHUNK];
    end
  end

  // Pipeline and output registers; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < PIPE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < LAST; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
        v_q[k] <= v_in[k];
      end
      out_valid <= v_in[LAST];
      sum       <= s_nx[LAST];
      carry_out <= c_nx[LAST];
    end
  end

`ifdef FLAGS_EN
  logic ovf_nx;
  logic zero_nx;

  // Operand sign bits reach the last stage inside the skewed operand words.
  assign ovf_nx  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
                && (s_nx[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
  assign zero_nx = (s_nx[LAST] == '0);

  // Flag registers advance in lockstep with sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (advance) begin
      overflow <= ovf_nx;
      zero     <= zero_nx;
    end
  end
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed scenarios plus a
// randomized run checked against a whole-word reference model.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int L      = STAGES - 1;
`ifdef FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input_0;
  logic [WIDTH-1:0] input_1;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_0(input_0), .input_1(input_1),
    .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference: a fixed-length delay line of whole-word results with a
  // single global advance; slot L is what the output must show.
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             z;
  } slot_t;

  slot_t m [STAGES];
  logic  exp_in_ready;
  logic  seen_in_ready;

  function automatic slot_t ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sb);
    slot_t          r;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   full;
    bp   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, cin};
    r.v  = 1'b1;
    r.s  = full[WIDTH-1:0];
    r.c  = full[WIDTH];
    r.o  = FLAGS && (a[WIDTH-1] == bp[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
    r.z  = FLAGS && (r.s == '0);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < STAGES; i++) m[i] = '0;
  endtask

  // One clock: drive at negedge, note in_ready, update model at posedge,
  // return at the next negedge so outputs can be sampled.
  task automatic tick(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sb, input logic ordy);
    slot_t nw;
    in_valid  = iv;
    input_0   = a;
    input_1   = b;
    carry_in  = cin;
    sub       = sb;
    out_ready = ordy;
    #1;
    seen_in_ready = in_ready;
    exp_in_ready  = !m[L].v || ordy;
    nw = iv ? ref_op(a, b, cin, sb) : slot_t'('0);
    @(posedge clk);
    if (exp_in_ready) begin
      for (int i = L; i > 0; i--) m[i] = m[i-1];
      m[0] = nw;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (sum !== '0) $display("FAIL rst_sum: got %h expected 0", sum); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if ({carry_out, overflow, zero} !== 3'b000)
      $display("FAIL rst_flags: got %b expected 000", {carry_out, overflow, zero}); else passed++;
    rst = 1'b0;
    model_clear();
    // One result at the output and three more behind it.
    for (int i = 0; i < 4; i++) tick(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || sum !== m[L].s)
      $display("FAIL pre_rst_result: got v=%b sum=%h expected v=1 sum=%h", out_valid, sum, m[L].s); else passed++;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL async_rst_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (sum !== '0) $display("FAIL async_rst_sum: got %h expected 0", sum); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL async_rst_in_ready: got %b expected 1", in_ready); else passed++;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      checks++; if (out_valid !== 1'b0) $display("FAIL stale_after_rst: cycle %0d got %b expected 0", i, out_valid); else passed++;
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    tick(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      idle(1'b1);
      lat++;
    end
    checks++; if (lat != STAGES) $display("FAIL ripple_latency: got %0d expected %0d", lat, STAGES); else passed++;
    checks++; if (sum !== 32'h0 || carry_out !== 1'b1)
      $display("FAIL ripple_sum: got %h c=%b expected 00000000 c=1", sum, carry_out); else passed++;
    checks++; if (zero !== FLAGS || overflow !== 1'b0)
      $display("FAIL ripple_flags: got z=%b o=%b expected z=%b o=0", zero, overflow, FLAGS); else passed++;
    idle(1'b1);
  endtask

  task automatic test_subtract();
    int lat;
    tick(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      idle(1'b1);
      lat++;
    end
    checks++; if (out_valid !== 1'b1) $display("FAIL sub_timeout: got out_valid=%b expected 1", out_valid); else passed++;
    checks++; if (sum !== 32'hFFFF_FFFE || carry_out !== 1'b0 || overflow !== 1'b0)
      $display("FAIL sub_result: got %h c=%b o=%b expected fffffffe c=0 o=0", sum, carry_out, overflow); else passed++;
    idle(1'b1);
  endtask

  task automatic test_overflow();
    int lat;
    tick(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      idle(1'b1);
      lat++;
    end
    checks++; if (sum !== 32'h8000_0000 || carry_out !== 1'b0)
      $display("FAIL ovf_sum: got %h c=%b expected 80000000 c=0", sum, carry_out); else passed++;
    checks++; if (overflow !== FLAGS) $display("FAIL ovf_flag: got %b expected %b", overflow, FLAGS); else passed++;
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) tick(1'b1, WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    checks++; if (out_valid !== 1'b1 || sum !== 32'd2)
      $display("FAIL b2b_first: got v=%b sum=%0d expected v=1 sum=2", out_valid, sum); else passed++;
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      checks++; if (seen_in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", seen_in_ready); else passed++;
      checks++; if (out_valid !== 1'b1 || sum !== 32'd2)
        $display("FAIL stall_hold: got v=%b sum=%0d expected v=1 sum=2", out_valid, sum); else passed++;
    end
    idle(1'b1);
    checks++; if (seen_in_ready !== 1'b1) $display("FAIL unstall_in_ready: got %b expected 1", seen_in_ready); else passed++;
    checks++; if (out_valid !== 1'b1 || sum !== 32'd4)
      $display("FAIL b2b_second: got v=%b sum=%0d expected v=1 sum=4", out_valid, sum); else passed++;
    idle(1'b1);
    checks++; if (out_valid !== 1'b1 || sum !== 32'd6)
      $display("FAIL b2b_third: got v=%b sum=%0d expected v=1 sum=6", out_valid, sum); else passed++;
    idle(1'b1);
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_bubble();
    logic [3:0] vpat;
    tick(1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    tick(1'b1, 32'd30, 32'd40, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    checks++; if (out_valid !== 1'b1 || sum !== 32'd30)
      $display("FAIL bubble_first: got v=%b sum=%0d expected v=1 sum=30", out_valid, sum); else passed++;
    vpat[3] = out_valid;
    idle(1'b1);
    vpat[2] = out_valid;
    idle(1'b1);
    vpat[1] = out_valid;
    checks++; if (out_valid !== 1'b1 || sum !== 32'd70)
      $display("FAIL bubble_second: got v=%b sum=%0d expected v=1 sum=70", out_valid, sum); else passed++;
    idle(1'b1);
    vpat[0] = out_valid;
    checks++; if (vpat !== 4'b1010) $display("FAIL bubble_pattern: got %b expected 1010", vpat); else passed++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
      tick($urandom_range(0, 3) != 0, a, b, 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
      checks++; if (seen_in_ready !== exp_in_ready)
        $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", n, seen_in_ready, exp_in_ready); else passed++;
      checks++; if (out_valid !== m[L].v)
        $display("FAIL rnd_out_valid: cycle %0d got %b expected %b", n, out_valid, m[L].v); else passed++;
      if (m[L].v) begin
        checks++; if ({carry_out, sum} !== {m[L].c, m[L].s})
          $display("FAIL rnd_result: cycle %0d got c=%b %h expected c=%b %h", n, carry_out, sum, m[L].c, m[L].s);
        else passed++;
        checks++; if ({overflow, zero} !== {m[L].o, m[L].z})
          $display("FAIL rnd_flags: cycle %0d got o=%b z=%b expected o=%b z=%b", n, overflow, zero, m[L].o, m[L].z);
        else passed++;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    input_0   = '0;
    input_1   = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_carry_ripple();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_bubble();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor of the single-cycle 32-bit adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, one chunk per pipeline stage.
- Uses a valid/ready handshake on both sides, so the ALU/EX path can run at higher clock rates and stall cleanly.
- Throughput is one operation per cycle; latency is STAGES cycles.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; CHUNK = WIDTH/STAGES bits are added per stage; STAGES=1 is legal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- input_0  input  WIDTH  operand A.
- input_1  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- sub  input  1  1 = invert input_1 before adding.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow (FLAGS_EN only, else 0).
- zero  output  1  sum == 0 (FLAGS_EN only, else 0).

Behaviour:
- Reset: on rst high, asynchronously clear every stage valid bit and all data registers. out_valid, sum, carry_out, overflow and zero read 0. in_ready reads 1. Any operation in flight is discarded, with no partial output.
- Operand B: B' = sub ? ~input_1 : input_1. The carry_in value is used unchanged, so a plain subtract needs sub=1 and carry_in=1.
- Global advance: advance = !out_valid || out_ready. All stages shift together when advance=1 and hold everything when advance=0.
- Input handshake: in_ready = advance, purely combinational from out_valid/out_ready. An operation is accepted when in_valid && in_ready.
- Bubbles: a cycle with in_valid=0 and advance=1 inserts a bubble (valid bit 0). Bubbles are not compressed.
- Stage k (0..STAGES-1): adds chunk k of A and B' plus the carry registered from stage k-1 (stage 0 uses carry_in). It registers the CHUNK-bit partial sum and the chunk carry.
- Skew registers: upper operand chunks are delayed into their stage. Already-computed lower sum chunks are delayed so all chunks align at the output register.
- Latency: an operation accepted on edge n is presented with out_valid=1 after edge n+STAGES-1 (STAGES cycles counting the accept cycle), provided no stall occurs. Each stall cycle adds exactly one cycle.
- Output stability: while out_valid=1 and out_ready=0, sum, carry_out and the flags are held stable.
- Full pipeline: a new input plus simultaneous output acceptance in the same cycle is legal and sustains 1 op/cycle.
- Arithmetic: {carry_out,sum} = input_0 + B' + carry_in, mod 2^(WIDTH+1). The result is bit-identical to the single-cycle adder when sub=0.
- Overflow: overflow = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]). The needed sign bits are pipelined with the data.
- Wrap-around: results wrap modulo 2^WIDTH. No saturation.
- STAGES=1: a single registered adder with the same handshake.

Optional Feature:
- FLAGS_EN, defined: overflow and zero are computed as above and registered alongside sum.
- FLAGS_EN, undefined: no sign pipelining or zero-detect logic is built; overflow and zero are tied to 0. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream with 3 ops in flight -> out_valid=0, sum=0, in_ready=1 immediately. No stale result appears after rst drops.
- Carry ripple across all chunks: 0xFFFFFFFF + 0x00000001, carry_in=0, sub=0, out_ready=1 -> after 4 cycles sum=0x00000000, carry_out=1, zero=1 (FLAGS_EN).
- Subtract: input_0=5, input_1=7, sub=1, carry_in=1 -> sum=0xFFFFFFFE, carry_out=0, overflow=0.
- Signed overflow: 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, carry_out=0, overflow=1 (FLAGS_EN), or overflow=0 with FLAGS_EN undefined.
- Back-to-back plus stall: issue 1+1, 2+2, 3+3 on consecutive cycles and hold out_ready=0 for 2 cycles once the first result is valid -> in_ready=0 during the stall, sum stays at 2 while stalled, then 2, 4, 6 emerge on consecutive cycles with no loss or duplication.
- Bubble handling: in_valid pattern 1,0,1 with 10+20 and 30+40 -> outputs 30 and 70 separated by exactly one out_valid=0 cycle.
